// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - D-stage stall/flush controller with MDU busy tracking
//
// Purpose: raises a pipeline stall when the D-stage instruction needs an
// operand that E or M cannot supply in time (Tuse/Tnew rule), or when it
// needs the mult/div unit while that unit is busy or just being started.
// The stall freezes PC and F/D and clears D/E. A saturating counter records
// every stalled cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   D_rs, D_rt                  source register fields of the D instruction
//   D_use_rs, D_use_rt          D instruction actually reads rs / rt
//   D_tuse_rs, D_tuse_rt        cycles until the operand is consumed
//   D_is_md                     D instruction touches the MDU
//   E_wa, E_tnew                E destination register and cycles to ready
//   M_wa, M_tnew                M destination register and cycles to ready
//   E_md_start, E_md_div        E starts the MDU this cycle; 1 = divide
//   F_hold, D_hold, E_flush     stall outputs (all equal)
//   md_busy                     MDU busy counter is nonzero
//   stall_cnt                   saturating count of stalled cycles
module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic             D_use_rs,
    input  logic             D_use_rt,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic             D_is_md,
    input  logic [4:0]       E_wa,
    input  logic [1:0]       E_tnew,
    input  logic [4:0]       M_wa,
    input  logic [1:0]       M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_div,
    output logic             F_hold,
    output logic             D_hold,
    output logic             E_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] md_cnt;
    logic       rs_haz;
    logic       rt_haz;
    logic       md_haz;
    logic       stall;

    // A producer whose result is ready no later than the consumer needs it is
    // covered by forwarding; only tnew > tuse forces a stall. $0 never stalls.
    always_comb begin
        rs_haz = D_use_rs && (D_rs != 5'd0) &&
                 (((E_wa == D_rs) && (E_tnew > D_tuse_rs)) ||
                  ((M_wa == D_rs) && (M_tnew > D_tuse_rs)));
        rt_haz = D_use_rt && (D_rt != 5'd0) &&
                 (((E_wa == D_rt) && (E_tnew > D_tuse_rt)) ||
                  ((M_wa == D_rt) && (M_tnew > D_tuse_rt)));
        // The start cycle itself stalls too: the counter only becomes nonzero
        // on the following edge. MDU terms are forced off while in reset.
        md_haz = rst_n && D_is_md && (md_busy || E_md_start);
        stall  = rs_haz || rt_haz || md_haz;
    end

    assign F_hold  = stall;
    assign D_hold  = stall;
    assign E_flush = stall;
    assign md_busy = (md_cnt != 4'd0);

    // A start while busy cannot happen (the D stall blocks it), so it is
    // simply ignored rather than reloading the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= 4'd0;
        end else if (E_md_start && (md_cnt == 4'd0)) begin
            md_cnt <= E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic        D_use_rs, D_use_rt, D_is_md, E_md_start, E_md_div;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        F_hold, D_hold, E_flush, md_busy;
    logic [31:0] stall_cnt;
    logic        F_hold2, D_hold2, E_flush2, md_busy2;
    logic [3:0]  stall_cnt2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .F_hold(F_hold), .D_hold(D_hold), .E_flush(E_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst2_n),
        .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .F_hold(F_hold2), .D_hold(D_hold2), .E_flush(E_flush2),
        .md_busy(md_busy2), .stall_cnt(stall_cnt2)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic       use_rs;
        logic [1:0] tuse_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic [1:0] tuse_rt;
        logic       is_md;
        logic [4:0] e_wa;
        logic [1:0] e_tnew;
        logic [4:0] m_wa;
        logic [1:0] m_tnew;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(logic [4:0] rs, logic urs, logic [1:0] trs,
                                logic [4:0] rt, logic urt, logic [1:0] trt,
                                logic md, logic [4:0] ewa, logic [1:0] etn,
                                logic [4:0] mwa, logic [1:0] mtn, logic st);
        vec_t v;
        v.rs = rs; v.use_rs = urs; v.tuse_rs = trs;
        v.rt = rt; v.use_rt = urt; v.tuse_rt = trt;
        v.is_md = md; v.e_wa = ewa; v.e_tnew = etn;
        v.m_wa = mwa; v.m_tnew = mtn; v.exp_stall = st;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        D_rs = v.rs; D_use_rs = v.use_rs; D_tuse_rs = v.tuse_rs;
        D_rt = v.rt; D_use_rt = v.use_rt; D_tuse_rt = v.tuse_rt;
        D_is_md = v.is_md; E_wa = v.e_wa; E_tnew = v.e_tnew;
        M_wa = v.m_wa; M_tnew = v.m_tnew;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        chk(name, {29'd0, F_hold, D_hold, E_flush}, {29'd0, {3{exp}}});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // A start while busy is illegal; the bench must never produce one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && E_md_start === 1'b1) begin
            n_cmp++;
            if (md_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL md_start_while_busy: got md_busy=%0b expected 0", md_busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t lw_use;
        vec_t idle;
        int   exp_cnt;
        int   busy_n;
        int   stall_seen;

        //          rs  urs trs  rt urt trt  md  ewa etn  mwa mtn  st
        idle   = mk(0,  0,  0,   0, 0,  0,   0,  0,  0,   0,  0,   0);
        lw_use = mk(8,  1,  1,   0, 0,  0,   0,  8,  2,   0,  0,   1);
        vecs[0]  = idle;
        vecs[1]  = lw_use;
        vecs[2]  = mk(9,  1, 1,  0, 0, 0,  0,  9, 1,  0, 0,  0);
        vecs[3]  = mk(0,  1, 1,  0, 0, 0,  0,  0, 2,  0, 0,  0);
        vecs[4]  = mk(0,  0, 0,  5, 1, 0,  0,  0, 0,  5, 1,  1);
        vecs[5]  = mk(0,  0, 0,  5, 1, 1,  0,  0, 0,  5, 1,  0);
        vecs[6]  = mk(8,  0, 0,  0, 0, 0,  0,  8, 2,  0, 0,  0);
        vecs[7]  = mk(3,  1, 0,  4, 1, 0,  0,  3, 2,  4, 1,  1);
        vecs[8]  = mk(12, 1, 0,  0, 0, 0,  0, 12, 2,  0, 0,  1);
        vecs[9]  = mk(8,  1, 0,  0, 0, 0,  0,  7, 2,  9, 1,  0);
        vecs[10] = mk(0,  0, 0,  0, 0, 0,  1,  0, 0,  0, 0,  0);
        vecs[11] = mk(0,  0, 0,  6, 1, 0,  0,  6, 1,  0, 0,  1);

        rst_n = 1'b0; rst2_n = 1'b0;
        E_md_start = 1'b0; E_md_div = 1'b0;
        apply(lw_use);
        #2;
        chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk_stall("reset_comb_stall", 1'b1);
        tick();
        chk("reset_cnt_after_edge", stall_cnt, 32'd0);
        rst_n = 1'b1;

        // Load-use: one stall, then the load in M is forwardable.
        apply(lw_use);
        #1;
        chk_stall("loaduse_stall", 1'b1);
        tick();
        chk("loaduse_cnt1", stall_cnt, 32'd1);
        E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd8; M_tnew = 2'd1;
        #1;
        chk_stall("loaduse_resolved", 1'b0);
        tick();
        chk("loaduse_cnt_hold", stall_cnt, 32'd1);

        exp_cnt = 1;
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            chk_stall($sformatf("vec%0d_stall", i), vecs[i].exp_stall);
            tick();
            exp_cnt += int'(vecs[i].exp_stall);
            chk($sformatf("vec%0d_cnt", i), stall_cnt, 32'(exp_cnt));
        end

        // Mult followed by mflo held in D.
        apply(idle);
        pulse_reset();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
        #1;
        chk_stall("mult_start_stall", 1'b1);
        chk("mult_start_busy", {31'd0, md_busy}, 32'd0);
        tick();
        E_md_start = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mult_busy%0d", i), {31'd0, md_busy}, 32'd1);
            chk_stall($sformatf("mult_stall%0d", i), 1'b1);
            tick();
        end
        chk("mult_busy_end", {31'd0, md_busy}, 32'd0);
        chk_stall("mult_stall_end", 1'b0);
        chk("mult_cnt", stall_cnt, 32'd6);

        // Div with a non-MD instruction in D.
        pulse_reset();
        D_is_md = 1'b0; E_md_start = 1'b1; E_md_div = 1'b1;
        #1;
        chk_stall("div_start_nomd", 1'b0);
        tick();
        E_md_start = 1'b0;
        busy_n = 0;
        stall_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (md_busy) busy_n++;
            if (F_hold) stall_seen++;
            tick();
        end
        chk("div_busy_cycles", 32'(busy_n), 32'd10);
        chk("div_nomd_stalls", 32'(stall_seen), 32'd0);

        // Reset three cycles into a div.
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b1;
        #1;
        tick();
        E_md_start = 1'b0;
        tick();
        tick();
        chk("midreset_pre_busy", {31'd0, md_busy}, 32'd1);
        chk("midreset_pre_cnt", stall_cnt, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, md_busy}, 32'd0);
        chk("midreset_cnt", stall_cnt, 32'd0);
        chk_stall("midreset_stall", 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_stall("postreset_md_stall", 1'b0);
        chk("postreset_busy", {31'd0, md_busy}, 32'd0);
        tick();
        chk("postreset_cnt", stall_cnt, 32'd0);

        // Saturation on the 4-bit instance.
        D_is_md = 1'b0;
        apply(lw_use);
        rst2_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_cnt%0d", k), {28'd0, stall_cnt2}, (k < 15) ? 32'(k) : 32'd15);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
